// File: rtl/pickup_pkg.sv
// rtl/pickup_pkg.sv - shared item state type and item world-position table
//
// Purpose : types and constants shared by pickup_slot and pickup_array.
// Contents: item_state_t  - per-item FSM state
//           ITEM_X0/Y0    - world position (top-left) of item i, 16 entries
package pickup_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_COLLECTED = 2'd1,
    ST_RESPAWN   = 2'd2
  } item_state_t;

  // Items 1 and 3 sit close together so one character can touch both at once.
  localparam int unsigned ITEM_X0 [16] = '{
    180, 300, 500, 310, 660, 780, 900, 100,
    240, 360, 480, 600, 720, 840, 960,  60
  };
  localparam int unsigned ITEM_Y0 [16] = '{
    290, 290, 290, 290, 200, 200, 200, 200,
    100, 100, 100, 100, 400, 400, 400, 400
  };

endpackage

// File: rtl/pickup_slot.sv
// rtl/pickup_slot.sv - one pickup item: overlap test, collect/respawn FSM, re-arm latch
//
// Purpose : tracks a single item at a fixed world position.
// Ports   : sys_clk, RST_N     - clock, asynchronous active-low reset
//           i_char_x/i_char_y  - character world position (top-left)
//           i_frame_tick       - one-cycle pulse per video frame
//           o_collect          - high in the cycle whose rising edge collects the item
//           o_en               - registered: item is ACTIVE (visible)
module pickup_slot
  import pickup_pkg::*;
#(
  parameter int                 COORD_W        = 10,
  parameter int                 ITEM_SIZE      = 12,
  parameter int                 CHAR_SIZE      = 12,
  parameter int                 RESPAWN_FRAMES = 0,
  parameter logic [COORD_W-1:0] IX             = '0,
  parameter logic [COORD_W-1:0] IY             = '0
) (
  input  logic               sys_clk,
  input  logic               RST_N,
  input  logic [COORD_W-1:0] i_char_x,
  input  logic [COORD_W-1:0] i_char_y,
  input  logic               i_frame_tick,
  output logic               o_collect,
  output logic               o_en
);

  localparam int               CNT_W       = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'((RESPAWN_FRAMES > 0) ? RESPAWN_FRAMES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             HAS_RESPAWN = (RESPAWN_FRAMES > 0);
  localparam logic [COORD_W:0] ISZ         = (COORD_W + 1)'(ITEM_SIZE);
  localparam logic [COORD_W:0] CSZ         = (COORD_W + 1)'(CHAR_SIZE);

  item_state_t      r_state;
  item_state_t      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_armed;
  logic             w_armed_next;
  logic             r_en;

  // One extra bit so the sums cannot wrap near the coordinate maximum.
  logic [COORD_W:0] w_cx;
  logic [COORD_W:0] w_cy;
  logic [COORD_W:0] w_ix;
  logic [COORD_W:0] w_iy;
  logic             w_overlap;

  assign w_cx = {1'b0, i_char_x};
  assign w_cy = {1'b0, i_char_y};
  assign w_ix = {1'b0, IX};
  assign w_iy = {1'b0, IY};

  assign w_overlap = (w_cx <= w_ix + ISZ) && (w_cx + CSZ >= w_ix) &&
                     (w_cy <= w_iy + ISZ) && (w_cy + CSZ >= w_iy);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    // Re-arm once the character has been clear of the item for a cycle.
    w_armed_next = r_armed | ~w_overlap;
    o_collect    = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (w_overlap && r_armed) begin
          o_collect    = 1'b1;
          w_state_next = ST_COLLECTED;
          w_armed_next = 1'b0;
        end
      end
      ST_COLLECTED: begin
        if (HAS_RESPAWN && i_frame_tick) begin
          w_state_next = ST_RESPAWN;
          w_cnt_next   = CNT_LOAD;
        end
      end
      ST_RESPAWN: begin
        if (i_frame_tick) begin
          if (r_cnt == '0) begin
            w_state_next = ST_ACTIVE;
          end else begin
            w_cnt_next = r_cnt - CNT_ONE;
          end
        end
      end
      default: w_state_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_ACTIVE;
      r_cnt   <= '0;
      r_armed <= 1'b1;
      r_en    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_armed <= w_armed_next;
      r_en    <= (w_state_next == ST_ACTIVE);
    end
  end

  assign o_en = r_en;

endmodule

// File: rtl/pickup_array.sv
// rtl/pickup_array.sv - array of pickup items with pending bits and lowest-index event arbiter
//
// Purpose : instantiates N_ITEMS pickup_slot items, records collections as pending
//           bits and reports them one at a time over a valid/ready handshake.
// Ports   : sys_clk, RST_N     - clock, asynchronous active-low reset
//           char_X/char_Y      - character world position (top-left)
//           bg_pos             - horizontal scroll offset
//           frame_tick         - one-cycle pulse per video frame
//           item_x/item_y      - packed item screen positions, item i at [i*COORD_W +: COORD_W]
//           en                 - item i visible/active
//           ev_valid/ev_idx    - collection event and its item index
//           ev_ready           - consumer accepts the presented event
module pickup_array
  import pickup_pkg::*;
#(
  parameter int N_ITEMS        = 4,
  parameter int COORD_W        = 10,
  parameter int ITEM_SIZE      = 12,
  parameter int CHAR_SIZE      = 12,
  parameter int RESPAWN_FRAMES = 0
) (
  input  logic                       sys_clk,
  input  logic                       RST_N,
  input  logic [COORD_W-1:0]         char_X,
  input  logic [COORD_W-1:0]         char_Y,
  input  logic [COORD_W-1:0]         bg_pos,
  input  logic                       frame_tick,
  output logic [N_ITEMS*COORD_W-1:0] item_x,
  output logic [N_ITEMS*COORD_W-1:0] item_y,
  output logic [N_ITEMS-1:0]         en,
  output logic                       ev_valid,
  output logic [3:0]                 ev_idx,
  input  logic                       ev_ready
);

  logic [N_ITEMS-1:0] w_collect;
  logic [N_ITEMS-1:0] r_pending;
  logic [N_ITEMS-1:0] w_clr;
  logic [N_ITEMS-1:0] w_avail;
  logic               r_ev_valid;
  logic [3:0]         r_ev_idx;
  logic [3:0]         w_next_idx;
  logic               w_accept;

  genvar g;
  generate
    for (g = 0; g < N_ITEMS; g++) begin : g_slot
      localparam logic [COORD_W-1:0] WX = COORD_W'(ITEM_X0[g]);
      localparam logic [COORD_W-1:0] WY = COORD_W'(ITEM_Y0[g]);

      pickup_slot #(
        .COORD_W        (COORD_W),
        .ITEM_SIZE      (ITEM_SIZE),
        .CHAR_SIZE      (CHAR_SIZE),
        .RESPAWN_FRAMES (RESPAWN_FRAMES),
        .IX             (WX),
        .IY             (WY)
      ) u_slot (
        .sys_clk      (sys_clk),
        .RST_N        (RST_N),
        .i_char_x     (char_X),
        .i_char_y     (char_Y),
        .i_frame_tick (frame_tick),
        .o_collect    (w_collect[g]),
        .o_en         (en[g])
      );

      // Screen X wraps modulo 2^COORD_W with the scroll.
      assign item_x[g*COORD_W +: COORD_W] = WX - bg_pos;
      assign item_y[g*COORD_W +: COORD_W] = WY;
    end
  endgenerate

  assign w_accept = r_ev_valid & ev_ready;
  assign w_clr    = w_accept ? (N_ITEMS'(1) << r_ev_idx) : '0;
  // Arbitration sees only bits that were pending before this edge, so a
  // collection lands in the event register one cycle after it is recorded.
  assign w_avail  = r_pending & ~w_clr;

  always_comb begin
    w_next_idx = '0;
    for (int k = N_ITEMS - 1; k >= 0; k--) begin
      if (w_avail[k]) begin
        w_next_idx = 4'(k);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      r_pending  <= '0;
      r_ev_valid <= 1'b0;
      r_ev_idx   <= '0;
    end else begin
      // A fresh collection of the accepted item wins over its clear.
      r_pending <= w_avail | w_collect;
      // The presented event is frozen until it is accepted.
      if (!r_ev_valid || w_accept) begin
        r_ev_valid <= |w_avail;
        r_ev_idx   <= w_next_idx;
      end
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_idx   = r_ev_idx;

endmodule

// File: tb/tb_pickup_array.sv
// tb/tb_pickup_array.sv - self-checking bench for pickup_array (default and respawning instances)
module tb_pickup_array;
  import pickup_pkg::*;

  localparam int NI  = 4;
  localparam int ISZ = 12;
  localparam int CSZ = 12;

  logic        sys_clk;
  logic        RST_N;
  logic [9:0]  char_X, char_Y, bg_pos;
  logic        frame_tick, ev_ready;
  logic [39:0] ix0, iy0, ix1, iy1;
  logic [3:0]  en0, en1, idx0, idx1;
  logic        v0, v1;

  pickup_array u_dut (
    .sys_clk(sys_clk), .RST_N(RST_N), .char_X(char_X), .char_Y(char_Y),
    .bg_pos(bg_pos), .frame_tick(frame_tick), .item_x(ix0), .item_y(iy0),
    .en(en0), .ev_valid(v0), .ev_idx(idx0), .ev_ready(ev_ready)
  );

  pickup_array #(.RESPAWN_FRAMES(3)) u_dut_rs (
    .sys_clk(sys_clk), .RST_N(RST_N), .char_X(char_X), .char_Y(char_Y),
    .bg_pos(bg_pos), .frame_tick(frame_tick), .item_x(ix1), .item_y(iy1),
    .en(en1), .ev_valid(v1), .ev_idx(idx1), .ev_ready(ev_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: item visible flag, frame ticks still needed to reappear
  // (-1 = never), "char has been clear since last collection", pending set,
  // and the presented event.
  bit act  [2][NI];
  int left [2][NI];
  bit clr  [2][NI];
  bit pend [2][NI];
  bit mv   [2];
  int midx [2];
  int rfv  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ovl(int i);
    int cx = int'(char_X);
    int cy = int'(char_Y);
    int x  = int'(ITEM_X0[i]);
    int y  = int'(ITEM_Y0[i]);
    return (cx <= x + ISZ) && (cx + CSZ >= x) && (cy <= y + ISZ) && (cy + CSZ >= y);
  endfunction

  function automatic logic [31:0] exp_en(int d);
    logic [31:0] r = '0;
    for (int i = 0; i < NI; i++) r[i] = act[d][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NI; i++) begin
        act[d][i] = 1'b1; left[d][i] = 0; clr[d][i] = 1'b1; pend[d][i] = 1'b0;
      end
      mv[d] = 1'b0; midx[d] = 0;
    end
  endtask

  task automatic compare_all();
    check("en_default",    exp_en(0), exp_en(0) == exp_en(0) ? {28'd0, en0} : 32'd0);
  endtask

  task automatic compare_outputs();
    check("en_default",    {28'd0, en0}, exp_en(0));
    check("valid_default", {31'd0, v0},  {31'd0, mv[0]});
    check("idx_default",   {28'd0, idx0}, 32'(midx[0]));
    check("en_respawn",    {28'd0, en1}, exp_en(1));
    check("valid_respawn", {31'd0, v1},  {31'd0, mv[1]});
    check("idx_respawn",   {28'd0, idx1}, 32'(midx[1]));
  endtask

  // One clock: evaluate the model on the pre-edge inputs, advance, compare.
  task automatic step();
    bit ov  [NI];
    bit col [2][NI];
    bit acc [2];
    for (int i = 0; i < NI; i++) ov[i] = ovl(i);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NI; i++) col[d][i] = act[d][i] && clr[d][i] && ov[i];
      acc[d] = mv[d] && ev_ready;
    end
    @(posedge sys_clk);
    for (int d = 0; d < 2; d++) begin
      if (!mv[d] || acc[d]) begin
        if (acc[d]) pend[d][midx[d]] = 1'b0;
        mv[d] = 1'b0;
        midx[d] = 0;
        for (int i = NI - 1; i >= 0; i--) begin
          if (pend[d][i]) begin
            mv[d] = 1'b1;
            midx[d] = i;
          end
        end
      end
      for (int i = 0; i < NI; i++) begin
        if (col[d][i]) begin
          pend[d][i] = 1'b1;
          act[d][i]  = 1'b0;
          clr[d][i]  = 1'b0;
          left[d][i] = (rfv[d] > 0) ? rfv[d] + 1 : -1;
        end else begin
          if (!ov[i]) clr[d][i] = 1'b1;
          if (!act[d][i] && frame_tick && left[d][i] > 0) begin
            left[d][i]--;
            if (left[d][i] == 0) act[d][i] = 1'b1;
          end
        end
      end
    end
    #1;
    compare_outputs();
  endtask

  // Asynchronous reset: outputs must settle without any clock edge.
  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    model_reset();
    check("rst_en_default",    {28'd0, en0}, 32'hF);
    check("rst_valid_default", {31'd0, v0},  32'd0);
    check("rst_idx_default",   {28'd0, idx0}, 32'd0);
    check("rst_en_respawn",    {28'd0, en1}, 32'hF);
    check("rst_valid_respawn", {31'd0, v1},  32'd0);
    @(negedge sys_clk);
    RST_N = 1'b1;
  endtask

  initial begin
    int ev_seen;
    int k;
    rfv[0] = 0;
    rfv[1] = 3;
    RST_N = 1'b1;
    char_X = 10'd0; char_Y = 10'd0; bg_pos = 10'd0;
    frame_tick = 1'b0; ev_ready = 1'b1;
    #2;
    do_reset();

    // Scroll wrap: world X 180 minus 200 is 1004 modulo 1024.
    bg_pos = 10'd200;
    #1;
    check("item_x0_wrap", {22'd0, ix0[9:0]}, 32'd1004);
    check("item_y0",      {22'd0, iy0[9:0]}, 32'd290);
    bg_pos = 10'd0;

    // Inclusive edge of item 0: 193 is outside, 192 touches.
    char_X = 10'd193; char_Y = 10'd290;
    step();
    check("outside_no_collect", {31'd0, en0[0]}, 32'd1);
    char_X = 10'd192;
    step();
    check("edge_collect_en", {31'd0, en0[0]}, 32'd0);
    check("edge_collect_valid_lag", {31'd0, v0}, 32'd0);
    step();
    check("edge_ev_valid", {31'd0, v0}, 32'd1);
    check("edge_ev_idx",   {28'd0, idx0}, 32'd0);
    step();
    check("edge_ev_one_cycle", {31'd0, v0}, 32'd0);

    // Basic collection, default instance never brings the item back.
    do_reset();
    char_X = 10'd174; char_Y = 10'd284;
    step();
    check("basic_en_fall", {31'd0, en0[0]}, 32'd0);
    step();
    check("basic_ev", {27'd0, v0, idx0}, 32'h10);
    char_X = 10'd0; char_Y = 10'd0;
    for (int t = 0; t < 12; t++) begin
      frame_tick = (t % 3 == 0);
      step();
    end
    frame_tick = 1'b0;
    char_X = 10'd174; char_Y = 10'd284;
    step();
    step();
    check("basic_stays_gone", {31'd0, en0[0]}, 32'd0);
    check("basic_no_reevent", {31'd0, v0}, 32'd0);

    // Items 1 and 3 together while the consumer stalls.
    do_reset();
    ev_ready = 1'b0;
    char_X = 10'd300; char_Y = 10'd290;
    step();
    char_X = 10'd0; char_Y = 10'd0;
    for (int t = 0; t < 5; t++) begin
      step();
      check("stall_valid", {31'd0, v0}, 32'd1);
      check("stall_idx_held", {28'd0, idx0}, 32'd1);
    end
    ev_ready = 1'b1;
    step();
    check("next_valid", {31'd0, v0}, 32'd1);
    check("next_idx", {28'd0, idx0}, 32'd3);
    step();
    check("drained", {31'd0, v0}, 32'd0);

    // Respawn after 1+3 frame ticks with the character parked on item 2.
    do_reset();
    char_X = 10'd500; char_Y = 10'd290;
    step();
    check("rs_collect", {31'd0, en1[2]}, 32'd0);
    ev_seen = 0;
    for (int t = 0; t < 4; t++) begin
      repeat (2) begin step(); ev_seen += int'(v1); end
      check("rs_hidden_before_tick", {31'd0, en1[2]}, 32'd0);
      frame_tick = 1'b1;
      step();
      ev_seen += int'(v1);
      frame_tick = 1'b0;
    end
    check("rs_back", {31'd0, en1[2]}, 32'd1);
    check("rs_default_gone", {31'd0, en0[2]}, 32'd0);
    repeat (5) begin step(); ev_seen += int'(v1); end
    check("rs_parked_single_event", 32'(ev_seen), 32'd1);
    check("rs_parked_visible", {31'd0, en1[2]}, 32'd1);
    char_X = 10'd0; char_Y = 10'd0;
    step();
    char_X = 10'd500; char_Y = 10'd290;
    step();
    check("rs_recollect", {31'd0, en1[2]}, 32'd0);
    step();
    check("rs_second_event", {27'd0, v1, idx1}, 32'h12);

    // Reset mid-respawn with an event held pending.
    do_reset();
    ev_ready = 1'b0;
    char_X = 10'd500; char_Y = 10'd290;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check("pre_reset_pending", {31'd0, v1}, 32'd1);
    do_reset();

    // Random traffic around the items, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        char_X = 10'($urandom_range(0, 1023));
        char_Y = 10'($urandom_range(0, 1023));
      end else begin
        k = $urandom_range(0, NI - 1);
        char_X = 10'(int'(ITEM_X0[k]) + $urandom_range(0, 32) - 16);
        char_Y = 10'(int'(ITEM_Y0[k]) + $urandom_range(0, 32) - 16);
      end
      frame_tick = ($urandom_range(0, 5) == 0);
      ev_ready   = ($urandom_range(0, 9) < 6);
      bg_pos     = 10'($urandom);
      if (c % 8 == 0) begin
        #1;
        for (int i = 0; i < NI; i++) begin
          check("rand_item_x", {22'd0, ix0[i*10 +: 10]}, (ITEM_X0[i] - 32'(bg_pos)) % 1024);
          check("rand_item_y", {22'd0, iy1[i*10 +: 10]}, ITEM_Y0[i]);
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pickup_array.md
PICKUP_ARRAY -- requirements
Module: pickup_array

Interface
REQ-001 The block SHALL have parameter N_ITEMS, default 4, meaning the number of independent pickup items (1..16).
REQ-002 The block SHALL have parameter COORD_W, default 10, meaning the coordinate width in bits.
REQ-003 The block SHALL have parameter ITEM_SIZE, default 12, meaning the item hitbox edge in pixels.
REQ-004 The block SHALL have parameter CHAR_SIZE, default 12, meaning the character hitbox edge in pixels.
REQ-005 The block SHALL have parameter RESPAWN_FRAMES, default 0, meaning frames until a collected item reappears, where 0 means the item never reappears.
REQ-006 The block SHALL have port sys_clk, input, 1 bit, meaning the system clock, rising edge.
REQ-007 The block SHALL have port RST_N, input, 1 bit, meaning an asynchronous, active-low reset.
REQ-008 The block SHALL have ports char_X and char_Y, input, COORD_W each, meaning the character world position (top-left corner).
REQ-009 The block SHALL have port bg_pos, input, COORD_W, meaning the horizontal scroll offset.
REQ-010 The block SHALL have port frame_tick, input, 1 bit, meaning a one-cycle pulse per video frame.
REQ-011 The block SHALL have ports item_x and item_y, output, N_ITEMS*COORD_W each, meaning packed item screen positions, with item i at bits [i*COORD_W +: COORD_W].
REQ-012 The block SHALL have port en, output, N_ITEMS, meaning item i is visible/active.
REQ-013 The block SHALL have ports ev_valid (output, 1), ev_idx (output, 4) and ev_ready (input, 1), meaning the collection-event handshake.

Function
REQ-014 Each item SHALL run its own FSM with states ACTIVE, COLLECTED and RESPAWN.
REQ-015 Overlap SHALL be inclusive AABB: char_X <= ix+ITEM_SIZE, char_X+CHAR_SIZE >= ix, char_Y <= iy+ITEM_SIZE and char_Y+CHAR_SIZE >= iy.
REQ-016 All overlap sums SHALL be computed in COORD_W+1 bits so that no wrap occurs near the coordinate maximum.
REQ-017 An item in ACTIVE SHALL go to COLLECTED on the clock edge where overlap is true, and its pending bit SHALL be set on that same edge.
REQ-018 From COLLECTED, the item SHALL move to RESPAWN on the next frame_tick if RESPAWN_FRAMES>0; otherwise it SHALL stay in COLLECTED until reset.
REQ-019 In RESPAWN, a per-item counter SHALL load RESPAWN_FRAMES-1 and decrement on each frame_tick.
REQ-020 When the RESPAWN counter is 0 at a frame_tick, the item SHALL return to ACTIVE.
REQ-021 An item returning to ACTIVE while overlapped SHALL NOT be re-collected until overlap has first been false for at least one cycle (re-arm latch).
REQ-022 en[i] SHALL be 1 only in ACTIVE, and SHALL be registered with the state.
REQ-023 item_x[i] SHALL equal the world X minus bg_pos modulo 2^COORD_W, combinationally; item_y[i] SHALL equal the world Y.
REQ-024 ev_valid SHALL be 1 whenever any pending bit is set, and ev_idx SHALL be the lowest set index.
REQ-025 ev_idx and ev_valid SHALL be registered, with latency from the collecting edge to ev_valid of 1 cycle.
REQ-026 On ev_valid&&ev_ready, the pending bit for ev_idx SHALL clear, and the next lowest pending index SHALL present on the following cycle.
REQ-027 ev_idx SHALL remain stable while ev_valid=1 and ev_ready=0, even if a lower-index item is collected in that time.
REQ-028 Newly collected items SHALL only join arbitration after the current event is accepted.
REQ-029 Any number of items collected in the same cycle SHALL each set their pending bit, with none lost.
REQ-030 A pending bit SHALL persist across respawn until its event is accepted.
REQ-031 A second collection of the same item while its pending bit is still set SHALL be merged into that one event.

Reset
REQ-032 Asserting RST_N low SHALL immediately put all items in ACTIVE with re-arm set, and SHALL set en to all ones, clear all pending bits, set ev_valid to 0, set ev_idx to 0 and clear all counters.
REQ-033 Reset mid-respawn or mid-handshake SHALL discard all progress and any outstanding events.

Structure
REQ-034 Shared package pickup_pkg SHALL hold the item state enum and the world-position table ITEM_X0/ITEM_Y0, 16 entries, with default item 0 at (180,290).
REQ-035 The per-item FSM, overlap test and respawn counter SHALL be a sub-module pickup_slot, instantiated N_ITEMS times by a generate loop.
REQ-036 pickup_array SHALL own the pending register, the arbiter and the handshake.

Verification
REQ-037 Defaults, char at (174,284), ev_ready=1 -> en[0] falls the next edge, ev_valid=1 with ev_idx=0 one cycle later for 1 cycle, and item 0 stays gone.
REQ-038 Char at (193,290), just outside item 0 -> no collection; char at (192,290) -> collected.
REQ-039 Items 1 and 3 overlapped in the same cycle with ev_ready=0 for 5 cycles -> ev_idx=1 held stable; after ready, 1 is accepted and then 3 is presented the next cycle.
REQ-040 RESPAWN_FRAMES=3, collect then park the char on the item -> en returns after the 1st+3 frame_ticks with no second event; after the char moves away and back -> a second event is raised.
REQ-041 bg_pos=200 with item 0 at world X 180 -> item_x[0]=1004 (wrap).
REQ-042 RST_N pulsed low mid-RESPAWN with an event pending -> en all ones and ev_valid=0 asynchronously.
